// File: rtl/fetch_stage_if.sv
// Instruction-memory port of the fetch stage. The memory is combinational:
// imem_rdata is valid in the same cycle imem_addr is presented.
interface fetch_stage_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;

  modport master (output imem_addr, input  imem_rdata);
  modport slave  (input  imem_addr, output imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// Minisys instruction-fetch stage with IF/ID pipeline register.
// Owns the PC, selects the next PC from sequential/jump/branch sources and flushes wrong-path fetches.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic                 clock,
  input  logic                 reset,
  // Handshake: no valid/ready on imem; the word for imem_addr is consumed on the
  // same rising edge it is presented. if_id_valid qualifies the IF/ID contents.
  fetch_stage_if.master        imem,
  input  logic                 stall,
  input  logic                 id_jmp,
  input  logic                 id_jal,
  input  logic                 id_jr,
  input  logic [31:0]          id_jr_target,
  input  logic                 ex_branch_taken,
  input  logic [31:0]          ex_branch_target,
  output logic [31:0]          if_id_instr,
  output logic [31:0]          if_id_pc_plus4,
  output logic                 if_id_valid,
  output logic                 flush_id_ex,
  output logic [31:0]          fetch_count
);

  typedef enum logic [1:0] {
    SEL_SEQ    = 2'd0,
    SEL_HOLD   = 2'd1,
    SEL_JUMP   = 2'd2,
    SEL_BRANCH = 2'd3
  } pc_sel_e;

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] count_q, count_d;

  logic [31:0] pc_plus4;
  logic [31:0] jump_target;
  logic [31:0] branch_target;
  logic        jump_req;
  pc_sel_e     pc_sel;

  assign pc_plus4      = pc_q + 32'd4;
  assign branch_target = {ex_branch_target[31:2], 2'b00};

  // A bubble in ID carries no decoded control, so its jump strobes are discarded.
  assign jump_req = valid_q & (id_jmp | id_jal | id_jr);

  always_comb begin
    jump_target = {pc4_q[31:28], instr_q[25:0], 2'b00};
    if (id_jr) begin
      jump_target = {id_jr_target[31:2], 2'b00};
    end
  end

  // The EX branch is older than anything in ID/IF, so it beats stall and jumps.
  always_comb begin
    pc_sel = SEL_SEQ;
    if (ex_branch_taken) begin
      pc_sel = SEL_BRANCH;
    end else if (stall) begin
      pc_sel = SEL_HOLD;
    end else if (jump_req) begin
      pc_sel = SEL_JUMP;
    end
  end

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    count_d = count_q;
    case (pc_sel)
      SEL_BRANCH: begin
        pc_d    = branch_target;
        instr_d = NOP_WORD;
        pc4_d   = 32'd0;
        valid_d = 1'b0;
      end
      SEL_HOLD: begin
        pc_d = pc_q;
      end
      SEL_JUMP: begin
        pc_d    = jump_target;
        instr_d = NOP_WORD;
        pc4_d   = 32'd0;
        valid_d = 1'b0;
      end
      default: begin
        pc_d    = pc_plus4;
        instr_d = imem.imem_rdata;
        pc4_d   = pc_plus4;
        valid_d = 1'b1;
        count_d = count_q + 32'd1;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_WORD;
      pc4_q   <= 32'd0;
      valid_q <= 1'b0;
      count_q <= 32'd0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign imem.imem_addr = pc_q;
  assign if_id_instr    = instr_q;
  assign if_id_pc_plus4 = pc4_q;
  assign if_id_valid    = valid_q;
  assign fetch_count    = count_q;
  assign flush_id_ex    = ex_branch_taken;

  // Address low bits and opcode field are architecturally dropped here.
  logic unused_bits;
  assign unused_bits = ^{id_jr_target[1:0], ex_branch_target[1:0], instr_q[31:26]};

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: expected IF/ID words go into a queue, a
// negedge monitor pops and compares whenever a new valid instruction is latched.
module tb_fetch_stage;

  logic        clock;
  logic        reset;
  logic        stall;
  logic        id_jmp, id_jal, id_jr;
  logic [31:0] id_jr_target;
  logic        ex_branch_taken;
  logic [31:0] ex_branch_target;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic        flush_id_ex;
  logic [31:0] fetch_count;
  logic        jmode;

  int total;
  int bad;
  logic [63:0] exp_q[$];
  logic [31:0] last_cnt;

  fetch_stage_if imem_bus ();

  // Memory model: word = address | 0x1000, except a j 0x40 at address 4 in jmode.
  assign imem_bus.imem_rdata = (jmode && imem_bus.imem_addr == 32'h4) ? 32'h0800_0010
                                                                      : (imem_bus.imem_addr | 32'h1000);

  fetch_stage #(.RESET_PC(32'h0), .NOP_WORD(32'h0)) dut (
    .clock            (clock),
    .reset            (reset),
    .imem             (imem_bus.master),
    .stall            (stall),
    .id_jmp           (id_jmp),
    .id_jal           (id_jal),
    .id_jr            (id_jr),
    .id_jr_target     (id_jr_target),
    .ex_branch_taken  (ex_branch_taken),
    .ex_branch_target (ex_branch_target),
    .if_id_instr      (if_id_instr),
    .if_id_pc_plus4   (if_id_pc_plus4),
    .if_id_valid      (if_id_valid),
    .flush_id_ex      (flush_id_ex),
    .fetch_count      (fetch_count)
  );

  // Clock/reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                             input logic [31:0] pc4, input logic valid, input logic [31:0] cnt);
    check({tag, "_pc"},    imem_bus.imem_addr, pc);
    check({tag, "_instr"}, if_id_instr, instr);
    check({tag, "_pc4"},   if_id_pc_plus4, pc4);
    check({tag, "_valid"}, {31'd0, if_id_valid}, {31'd0, valid});
    check({tag, "_count"}, fetch_count, cnt);
  endtask

  task automatic push(input logic [31:0] instr, input logic [31:0] pc4);
    exp_q.push_back({instr, pc4});
  endtask

  // Driver: inputs applied at negedge, one rising edge, back to the next negedge.
  task automatic cycle(input logic st, input logic jm, input logic jl, input logic jr,
                       input logic [31:0] jr_t, input logic br, input logic [31:0] br_t);
    stall            = st;
    id_jmp           = jm;
    id_jal           = jl;
    id_jr            = jr;
    id_jr_target     = jr_t;
    ex_branch_taken  = br;
    ex_branch_target = br_t;
    @(posedge clock);
    @(negedge clock);
  endtask

  // Scoreboard monitor
  always @(negedge clock) begin
    if (!reset && if_id_valid && fetch_count != last_cnt) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got instr %h pc4 %h with no entry expected", if_id_instr, if_id_pc_plus4);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("sb_instr", if_id_instr, e[63:32]);
        check("sb_pc4", if_id_pc_plus4, e[31:0]);
      end
    end
    last_cnt = fetch_count;
  end

  initial begin
    total = 0;
    bad = 0;
    last_cnt = 32'd0;
    jmode = 1'b0;
    reset = 1'b1;
    stall = 1'b0;
    id_jmp = 1'b0;
    id_jal = 1'b0;
    id_jr = 1'b0;
    id_jr_target = 32'd0;
    ex_branch_taken = 1'b0;
    ex_branch_target = 32'd0;
    #1;
    check_state("reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
    check("reset_flush", {31'd0, flush_id_ex}, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // T1: sequential fetch
    push(32'h1000, 32'h4);
    cycle(0, 0, 0, 0, 0, 0, 0);
    check_state("t1_e1", 32'h4, 32'h1000, 32'h4, 1'b1, 32'd1);
    push(32'h1004, 32'h8);
    cycle(0, 0, 0, 0, 0, 0, 0);
    push(32'h1008, 32'hC);
    cycle(0, 0, 0, 0, 0, 0, 0);
    check_state("t1_e3", 32'hC, 32'h1008, 32'hC, 1'b1, 32'd3);
    check("t1_flush", {31'd0, flush_id_ex}, 32'd0);

    // T2: two stall cycles freeze everything, then resume
    cycle(1, 0, 0, 0, 0, 0, 0);
    check_state("t2_s1", 32'hC, 32'h1008, 32'hC, 1'b1, 32'd3);
    cycle(1, 0, 0, 0, 0, 0, 0);
    check_state("t2_s2", 32'hC, 32'h1008, 32'hC, 1'b1, 32'd3);
    push(32'h100C, 32'h10);
    cycle(0, 0, 0, 0, 0, 0, 0);
    check_state("t2_res", 32'h10, 32'h100C, 32'h10, 1'b1, 32'd4);

    // T3: steer to address 4 holding j 0x40, then take the jump
    jmode = 1'b1;
    cycle(0, 0, 0, 0, 0, 1, 32'h4);
    check_state("t3_br", 32'h4, 32'h0, 32'h0, 1'b0, 32'd4);
    push(32'h0800_0010, 32'h8);
    cycle(0, 0, 0, 0, 0, 0, 0);
    check_state("t3_jin", 32'h8, 32'h0800_0010, 32'h8, 1'b1, 32'd5);
    cycle(0, 1, 0, 0, 0, 0, 0);
    check_state("t3_jmp", 32'h40, 32'h0, 32'h0, 1'b0, 32'd5);
    // jump strobe while IF/ID is a bubble must be ignored
    push(32'h1040, 32'h44);
    cycle(0, 1, 0, 0, 0, 0, 0);
    check_state("t3_ign", 32'h44, 32'h1040, 32'h44, 1'b1, 32'd6);
    jmode = 1'b0;

    // T4: jr under stall holds, then jr redirects with low bits cleared
    cycle(1, 0, 0, 1, 32'h123, 0, 0);
    check_state("t4_st", 32'h44, 32'h1040, 32'h44, 1'b1, 32'd6);
    cycle(0, 0, 0, 1, 32'h123, 0, 0);
    check_state("t4_jr", 32'h120, 32'h0, 32'h0, 1'b0, 32'd6);
    push(32'h1120, 32'h124);
    cycle(0, 0, 0, 0, 0, 0, 0);
    check_state("t4_seq", 32'h124, 32'h1120, 32'h124, 1'b1, 32'd7);

    // T5: branch beats stall and jump; flush is combinational
    stall = 1'b1;
    id_jmp = 1'b1;
    ex_branch_taken = 1'b1;
    ex_branch_target = 32'h203;
    #1;
    check("t5_flush", {31'd0, flush_id_ex}, 32'd1);
    cycle(1, 1, 0, 0, 0, 1, 32'h203);
    check_state("t5_br", 32'h200, 32'h0, 32'h0, 1'b0, 32'd7);
    push(32'h1200, 32'h204);
    cycle(0, 0, 0, 0, 0, 0, 0);
    check_state("t5_seq", 32'h204, 32'h1200, 32'h204, 1'b1, 32'd8);

    // T6: wrap at top of address space, then asynchronous reset mid-stall
    cycle(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC);
    check_state("t6_top", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 32'd8);
    push(32'hFFFF_FFFC, 32'h0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    check_state("t6_wrap", 32'h0, 32'hFFFF_FFFC, 32'h0, 1'b1, 32'd9);
    stall = 1'b1;
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    check_state("t6_arst", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    push(32'h1000, 32'h4);
    cycle(0, 0, 0, 0, 0, 0, 0);
    check_state("t6_post", 32'h4, 32'h1000, 32'h4, 1'b1, 32'd1);

    cycle(1, 0, 0, 0, 0, 0, 0);
    check("sb_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
